hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32 core.
- Produces the stall, flush and forwarding controls consumed by the fetch, decode and execute pipeline registers and the execute-stage operand muxes. It is the driver of FlushE/StallD/StallF.
- Adds a post-reset drain sequencer that holds the front end flushed for a fixed number of cycles.
- Keeps wrap-around event counters of load-use stalls and control flushes for performance debug.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/hazard_unit_if.sv | 35 +++
 rtl/hazard_forward_sel.sv | 25 ++
 rtl/hazard_unit.sv | 89 ++++++++
 tb/tb_hazard_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings for the RV32 core: forward selects, result-source
// codes and the hazard sequencer states.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        HOLD,
        RUN
    } hz_state_e;

    // x0 is hard-wired zero, so it never matches for hazard purposes
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard controller bundle: stage register ids in, stall/flush/forward and
// event counters out.
interface hazard_unit_if
    import pipeline_pkg::*;
#(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           Rs1D, Rs2D;
    logic [4:0]           Rs1E, Rs2E, RdE;
    logic [1:0]           ResultSrcE;
    logic                 PCSrcE;
    logic [4:0]           RdM;
    logic                 RegWriteM;
    logic [4:0]           RdW;
    logic                 RegWriteW;
    logic                 StallF, StallD;
    logic                 FlushD, FlushE;
    fwd_sel_e             ForwardAE, ForwardBE;
    logic [CNT_WIDTH-1:0] StallCount, FlushCount;

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, RdW, RegWriteW,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               StallCount, FlushCount
    );

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, RdW, RegWriteW,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_forward_sel.sv
// Forward select for one execute-stage operand; memory stage has priority
// over writeback since it holds the younger result.
module hazard_forward_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    input  logic       hold,
    output fwd_sel_e   sel
);

    always_comb begin
        sel = FWD_RF;
        if (!hold) begin
            if (reg_write_m && reg_match(rd_m, rs_e))
                sel = FWD_MEM;
            else if (reg_write_w && reg_match(rd_w, rs_e))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward controller for the 5-stage core, with a post-reset
// drain sequencer and wrap-around load-use / control-flush event counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input  logic   clk,
    input  logic   reset,
    hazard_unit_if.slave hz
);

    localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

    hz_state_e            state, state_nxt;
    logic [3:0]           drain, drain_nxt;
    logic                 hold;
    logic                 lw_stall;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HOLD;
            drain <= DRAIN_INIT;
        end else begin
            state <= state_nxt;
            drain <= drain_nxt;
        end
    end

    // Leave HOLD on the edge where the drain counter has reached zero
    always_comb begin
        state_nxt = state;
        drain_nxt = drain;
        if (state == HOLD) begin
            if (drain == 4'd0)
                state_nxt = RUN;
            else
                drain_nxt = drain - 4'd1;
        end
    end

    assign hold     = reset || (state == HOLD);
    assign lw_stall = (hz.ResultSrcE == RESULT_SRC_LOAD) &&
                      (reg_match(hz.RdE, hz.Rs1D) || reg_match(hz.RdE, hz.Rs2D));

    assign hz.StallF = hold || lw_stall;
    assign hz.StallD = !hold && lw_stall;
    assign hz.FlushD = hold || hz.PCSrcE;
    assign hz.FlushE = hold || lw_stall || hz.PCSrcE;

    // A stall coinciding with a redirect is squashed, so only the flush counts
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == RUN) begin
            if (lw_stall && !hz.PCSrcE)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (hz.PCSrcE)
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end

    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;

    hazard_forward_sel u_fwd_a (
        .rs_e        (hz.Rs1E),
        .rd_m        (hz.RdM),
        .reg_write_m (hz.RegWriteM),
        .rd_w        (hz.RdW),
        .reg_write_w (hz.RegWriteW),
        .hold        (hold),
        .sel         (hz.ForwardAE)
    );

    hazard_forward_sel u_fwd_b (
        .rs_e        (hz.Rs2E),
        .rd_m        (hz.RdM),
        .reg_write_m (hz.RegWriteM),
        .rd_w        (hz.RdW),
        .reg_write_w (hz.RegWriteW),
        .hold        (hold),
        .sel         (hz.ForwardBE)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: 32-bit and 4-bit counter instances driven
// in lockstep against a cycle model of the controller.
module tb_hazard_unit;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_WIDTH(32)) hz ();
    hazard_unit_if #(.CNT_WIDTH(4))  hz4 ();

    hazard_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    hazard_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz4.slave)
    );

    assign hz4.Rs1D       = hz.Rs1D;
    assign hz4.Rs2D       = hz.Rs2D;
    assign hz4.Rs1E       = hz.Rs1E;
    assign hz4.Rs2E       = hz.Rs2E;
    assign hz4.RdE        = hz.RdE;
    assign hz4.ResultSrcE = hz.ResultSrcE;
    assign hz4.PCSrcE     = hz.PCSrcE;
    assign hz4.RdM        = hz.RdM;
    assign hz4.RegWriteM  = hz.RegWriteM;
    assign hz4.RdW        = hz.RdW;
    assign hz4.RegWriteW  = hz.RegWriteW;

    typedef struct {
        string       tag;
        logic        sf, sd, fd, fe;
        logic [1:0]  fa, fb;
        logic [31:0] sc, fc;
        logic [3:0]  fc4;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // model state
    bit          m_run;
    int          m_drain;
    logic [31:0] m_sc, m_fc;
    logic [3:0]  m_fc4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] mdl_fwd(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_in();
        hz.Rs1D = 5'd1; hz.Rs2D = 5'd2; hz.Rs1E = 5'd3; hz.Rs2E = 5'd4;
        hz.RdE = 5'd9; hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
        hz.RdM = 5'd10; hz.RegWriteM = 1'b0; hz.RdW = 5'd11; hz.RegWriteW = 1'b0;
    endtask

    task automatic rand_in();
        hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
        hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
        hz.RdE  = 5'($urandom_range(0, 3)); hz.ResultSrcE = 2'($urandom_range(0, 3));
        hz.PCSrcE = 1'($urandom_range(0, 1));
        hz.RdM = 5'($urandom_range(0, 3)); hz.RegWriteM = 1'($urandom_range(0, 1));
        hz.RdW = 5'($urandom_range(0, 3)); hz.RegWriteW = 1'($urandom_range(0, 1));
    endtask

    // Inputs are already set; push the expectation, check at negedge, then
    // advance the model across the next rising edge.
    task automatic step(input string tag);
        exp_t e, o;
        logic hold, lw, pc;
        hold = reset || !m_run;
        lw   = (hz.ResultSrcE == 2'b01) && (hz.RdE != 0) &&
               (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        pc   = hz.PCSrcE;
        e.tag = tag;
        e.sf  = hold | lw;
        e.sd  = !hold & lw;
        e.fd  = hold | pc;
        e.fe  = hold | lw | pc;
        e.fa  = hold ? 2'b00 : mdl_fwd(hz.Rs1E);
        e.fb  = hold ? 2'b00 : mdl_fwd(hz.Rs2E);
        e.sc  = m_sc;
        e.fc  = m_fc;
        e.fc4 = m_fc4;
        q.push_back(e);

        @(negedge clk);
        o = q.pop_front();
        chk({o.tag, ".StallF"},  32'(hz.StallF),     32'(o.sf));
        chk({o.tag, ".StallD"},  32'(hz.StallD),     32'(o.sd));
        chk({o.tag, ".FlushD"},  32'(hz.FlushD),     32'(o.fd));
        chk({o.tag, ".FlushE"},  32'(hz.FlushE),     32'(o.fe));
        chk({o.tag, ".FwdA"},    32'(hz.ForwardAE),  32'(o.fa));
        chk({o.tag, ".FwdB"},    32'(hz.ForwardBE),  32'(o.fb));
        chk({o.tag, ".StallCnt"}, hz.StallCount,     o.sc);
        chk({o.tag, ".FlushCnt"}, hz.FlushCount,     o.fc);
        chk({o.tag, ".FlushCnt4"}, 32'(hz4.FlushCount), 32'(o.fc4));

        if (reset) begin
            m_run = 0; m_drain = 2; m_sc = 0; m_fc = 0; m_fc4 = 0;
        end else if (!m_run) begin
            if (m_drain == 0) m_run = 1;
            else m_drain--;
        end else begin
            if (lw && !pc) m_sc++;
            if (pc) begin m_fc++; m_fc4++; end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        m_run = 0; m_drain = 2; m_sc = 0; m_fc = 0; m_fc4 = 0;
        @(posedge clk);
        #1;

        // reset cycles carry a live hazard that must be overridden
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd1; hz.RegWriteM = 1'b1; hz.RdM = 5'd3;
        step("rst0");
        step("rst1");
        idle_in();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("drain");
        step("run0");
        chk("drain_done.FlushE", 32'(hz.FlushE), 32'd0);

        // load-use hazard, then x0 destination
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
        step("lw");
        idle_in();
        step("lw_after");
        chk("lw.count", hz.StallCount, 32'd1);
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
        step("lw_x0");

        // forwarding priority
        idle_in();
        hz.RegWriteM = 1'b1; hz.RdM = 5'd7; hz.RegWriteW = 1'b1; hz.RdW = 5'd7;
        hz.Rs1E = 5'd7; hz.Rs2E = 5'd7;
        step("fwd_mem");
        hz.RegWriteM = 1'b0;
        step("fwd_wb");
        hz.RdW = 5'd0; hz.Rs1E = 5'd0;
        step("fwd_x0");

        // redirect together with load-use
        idle_in();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd6; hz.Rs2D = 5'd6; hz.PCSrcE = 1'b1;
        step("lw_pc");
        idle_in();
        step("lw_pc_after");
        chk("lw_pc.stallcnt", hz.StallCount, 32'd1);
        chk("lw_pc.flushcnt", hz.FlushCount, 32'd1);

        // 16 redirects wrap the 4-bit counter back to its prior value
        hz.PCSrcE = 1'b1;
        for (int i = 0; i < 16; i++) step("pc_wrap");
        idle_in();
        step("pc_wrap_after");
        chk("wrap.fc4", 32'(hz4.FlushCount), 32'd1);
        chk("wrap.fc32", hz.FlushCount, 32'd17);

        for (int i = 0; i < 40; i++) begin rand_in(); step("rand_a"); end

        // reset mid-RUN while a load-use stall is active
        idle_in();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd2; hz.Rs2D = 5'd2;
        reset = 1'b1;
        step("mid_rst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("redrain");
        step("rerun");

        for (int i = 0; i < 30; i++) begin rand_in(); step("rand_b"); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
